// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with a priority forwarding network per source operand.
// Also provides stall-time operand refresh, a not-ready hazard request and a saturating stall counter.
module id_ex_fwd_stage #(
    parameter int DATA_W   = 32,
    parameter int REG_ID_W = 5,
    parameter int NUM_OPS  = 2,
    parameter int NUM_FWD  = 2,
    parameter int CTRL_W   = 8,
    parameter int CNT_W    = 16
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         bubble,
    input  logic                         in_valid,
    input  logic [31:0]                  in_pc,
    input  logic [31:0]                  in_next_pc,
    input  logic [31:0]                  in_ins,
    input  logic [DATA_W-1:0]            in_immd,
    input  logic [NUM_OPS*DATA_W-1:0]    in_ops,
    input  logic [NUM_OPS*REG_ID_W-1:0]  in_op_ids,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic                         in_reg_write,
    input  logic [REG_ID_W-1:0]          in_reg_dst_id,
    input  logic [NUM_FWD-1:0]           fwd_reg_write,
    input  logic [NUM_FWD*REG_ID_W-1:0]  fwd_dst_id,
    input  logic [NUM_FWD*DATA_W-1:0]    fwd_result,
    input  logic [NUM_FWD-1:0]           fwd_ready,
    output logic                         out_valid,
    output logic [31:0]                  out_pc,
    output logic [31:0]                  out_next_pc,
    output logic [31:0]                  out_ins,
    output logic [DATA_W-1:0]            out_immd,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [REG_ID_W-1:0]          out_reg_dst_id,
    output logic [NUM_OPS*DATA_W-1:0]    out_ops,
    output logic                         out_reg_write,
    output logic                         out_hazard,
    output logic [CNT_W-1:0]             perf_stall_cnt
);

    logic                valid_q;
    logic [31:0]         pc_q;
    logic [31:0]         next_pc_q;
    logic [31:0]         ins_q;
    logic [DATA_W-1:0]   immd_q;
    logic [CTRL_W-1:0]   ctrl_q;
    logic                reg_write_q;
    logic [REG_ID_W-1:0] reg_dst_id_q;
    logic [DATA_W-1:0]   ops_q    [NUM_OPS];
    logic [REG_ID_W-1:0] op_ids_q [NUM_OPS];
    logic [CNT_W-1:0]    stall_cnt_q;

    logic [NUM_OPS-1:0]  win_found;
    logic [NUM_OPS-1:0]  win_ready;
    logic [DATA_W-1:0]   win_result [NUM_OPS];

    // Scan sources from lowest priority upward so the lowest matching index overwrites the rest.
    always_comb begin
        for (int k = 0; k < NUM_OPS; k++) begin
            win_found[k]  = 1'b0;
            win_ready[k]  = 1'b0;
            win_result[k] = '0;
            for (int j = NUM_FWD - 1; j >= 0; j--) begin
                if (valid_q && fwd_reg_write[j] &&
                    (fwd_dst_id[j*REG_ID_W +: REG_ID_W] != '0) &&
                    (fwd_dst_id[j*REG_ID_W +: REG_ID_W] == op_ids_q[k])) begin
                    win_found[k]  = 1'b1;
                    win_ready[k]  = fwd_ready[j];
                    win_result[k] = fwd_result[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        out_ops = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (win_found[k] && win_ready[k]) begin
                out_ops[k*DATA_W +: DATA_W] = win_result[k];
            end else begin
                out_ops[k*DATA_W +: DATA_W] = ops_q[k];
            end
        end
    end

    assign out_hazard     = |(win_found & ~win_ready);
    assign out_valid      = valid_q;
    assign out_pc         = pc_q;
    assign out_next_pc    = next_pc_q;
    assign out_ins        = ins_q;
    assign out_immd       = immd_q;
    assign out_ctrl       = ctrl_q;
    assign out_reg_dst_id = reg_dst_id_q;
    assign out_reg_write  = reg_write_q & valid_q;
    assign perf_stall_cnt = stall_cnt_q;

    // While stalled, latch any ready forwarded value so it outlives the producing stage.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            next_pc_q    <= '0;
            ins_q        <= '0;
            immd_q       <= '0;
            ctrl_q       <= '0;
            reg_write_q  <= 1'b0;
            reg_dst_id_q <= '0;
            stall_cnt_q  <= '0;
            for (int k = 0; k < NUM_OPS; k++) begin
                ops_q[k]    <= '0;
                op_ids_q[k] <= '0;
            end
        end else if (stall) begin
            for (int k = 0; k < NUM_OPS; k++) begin
                if (win_found[k] && win_ready[k]) begin
                    ops_q[k] <= win_result[k];
                end
            end
            if (valid_q && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end else if (bubble) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            next_pc_q    <= '0;
            ins_q        <= '0;
            immd_q       <= '0;
            ctrl_q       <= '0;
            reg_write_q  <= 1'b0;
            reg_dst_id_q <= '0;
            for (int k = 0; k < NUM_OPS; k++) begin
                ops_q[k]    <= '0;
                op_ids_q[k] <= '0;
            end
        end else begin
            valid_q      <= in_valid;
            pc_q         <= in_pc;
            next_pc_q    <= in_next_pc;
            ins_q        <= in_ins;
            immd_q       <= in_immd;
            ctrl_q       <= in_ctrl;
            reg_write_q  <= in_reg_write;
            reg_dst_id_q <= in_reg_dst_id;
            for (int k = 0; k < NUM_OPS; k++) begin
                ops_q[k]    <= in_ops[k*DATA_W +: DATA_W];
                op_ids_q[k] <= in_op_ids[k*REG_ID_W +: REG_ID_W];
            end
        end
    end

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Randomized self-checking bench for id_ex_fwd_stage against a behavioural stage model.
module tb_id_ex_fwd_stage;

    localparam int DW   = 32;
    localparam int IW   = 5;
    localparam int NOPS = 2;
    localparam int NFWD = 2;
    localparam int CW   = 8;
    localparam int CNTW = 2;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    logic                 sys_clk = 1'b0;
    logic                 rst = 1'b1, stall = 1'b0, bubble = 1'b0, in_valid = 1'b0;
    logic [31:0]          in_pc = '0, in_next_pc = '0, in_ins = '0;
    logic [DW-1:0]        in_immd = '0;
    logic [NOPS*DW-1:0]   in_ops = '0;
    logic [NOPS*IW-1:0]   in_op_ids = '0;
    logic [CW-1:0]        in_ctrl = '0;
    logic                 in_reg_write = 1'b0;
    logic [IW-1:0]        in_reg_dst_id = '0;
    logic [NFWD-1:0]      fwd_reg_write = '0;
    logic [NFWD*IW-1:0]   fwd_dst_id = '0;
    logic [NFWD*DW-1:0]   fwd_result = '0;
    logic [NFWD-1:0]      fwd_ready = '0;
    logic                 out_valid, out_reg_write, out_hazard;
    logic [31:0]          out_pc, out_next_pc, out_ins;
    logic [DW-1:0]        out_immd;
    logic [CW-1:0]        out_ctrl;
    logic [IW-1:0]        out_reg_dst_id;
    logic [NOPS*DW-1:0]   out_ops;
    logic [CNTW-1:0]      perf_stall_cnt;

    int total = 0;
    int bad = 0;

    // Model of what the stage should currently hold.
    logic          m_valid, m_rw;
    logic [31:0]   m_pc, m_npc, m_ins;
    logic [DW-1:0] m_immd;
    logic [CW-1:0] m_ctrl;
    logic [IW-1:0] m_dst;
    logic [DW-1:0] m_ops [NOPS];
    logic [IW-1:0] m_ids [NOPS];
    int            m_cnt;

    id_ex_fwd_stage #(.DATA_W(DW), .REG_ID_W(IW), .NUM_OPS(NOPS), .NUM_FWD(NFWD),
                      .CTRL_W(CW), .CNT_W(CNTW)) dut (
        .sys_clk(sys_clk), .rst(rst), .stall(stall), .bubble(bubble), .in_valid(in_valid),
        .in_pc(in_pc), .in_next_pc(in_next_pc), .in_ins(in_ins), .in_immd(in_immd),
        .in_ops(in_ops), .in_op_ids(in_op_ids), .in_ctrl(in_ctrl),
        .in_reg_write(in_reg_write), .in_reg_dst_id(in_reg_dst_id),
        .fwd_reg_write(fwd_reg_write), .fwd_dst_id(fwd_dst_id), .fwd_result(fwd_result),
        .fwd_ready(fwd_ready), .out_valid(out_valid), .out_pc(out_pc),
        .out_next_pc(out_next_pc), .out_ins(out_ins), .out_immd(out_immd),
        .out_ctrl(out_ctrl), .out_reg_dst_id(out_reg_dst_id), .out_ops(out_ops),
        .out_reg_write(out_reg_write), .out_hazard(out_hazard), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic int winner(int k);
        for (int j = 0; j < NFWD; j++) begin
            if (m_valid && fwd_reg_write[j] && fwd_dst_id[j*IW +: IW] != 0 &&
                fwd_dst_id[j*IW +: IW] == m_ids[k]) return j;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] exp_op(int k);
        int w = winner(k);
        if (w >= 0 && fwd_ready[w]) return fwd_result[w*DW +: DW];
        return m_ops[k];
    endfunction

    function automatic logic exp_hazard();
        for (int k = 0; k < NOPS; k++) begin
            int w = winner(k);
            if (w >= 0 && !fwd_ready[w]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [NOPS*DW-1:0] exp_ops_vec();
        logic [NOPS*DW-1:0] v;
        for (int k = 0; k < NOPS; k++) v[k*DW +: DW] = exp_op(k);
        return v;
    endfunction

    task automatic model_clear(input logic keep_cnt);
        m_valid = 0; m_rw = 0; m_pc = 0; m_npc = 0; m_ins = 0; m_immd = 0; m_ctrl = 0; m_dst = 0;
        for (int k = 0; k < NOPS; k++) begin m_ops[k] = 0; m_ids[k] = 0; end
        if (!keep_cnt) m_cnt = 0;
    endtask

    // Advance the model using the inputs present before the edge, then clock the DUT.
    task automatic tick();
        if (rst) begin
            model_clear(1'b0);
        end else if (stall) begin
            for (int k = 0; k < NOPS; k++) m_ops[k] = exp_op(k);
            if (m_valid && m_cnt < CNT_MAX) m_cnt++;
        end else if (bubble) begin
            model_clear(1'b1);
        end else begin
            m_valid = in_valid; m_rw = in_reg_write; m_pc = in_pc; m_npc = in_next_pc;
            m_ins = in_ins; m_immd = in_immd; m_ctrl = in_ctrl; m_dst = in_reg_dst_id;
            for (int k = 0; k < NOPS; k++) begin
                m_ops[k] = in_ops[k*DW +: DW];
                m_ids[k] = in_op_ids[k*IW +: IW];
            end
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic rand_inputs();
        in_valid = 1'($urandom); in_pc = $urandom; in_next_pc = $urandom; in_ins = $urandom;
        in_immd = $urandom; in_ops = {$urandom, $urandom}; in_op_ids = NOPS*IW'($urandom);
        in_ctrl = CW'($urandom); in_reg_write = 1'($urandom); in_reg_dst_id = IW'($urandom);
        fwd_reg_write = NFWD'($urandom); fwd_dst_id = NFWD*IW'($urandom);
        fwd_result = {$urandom, $urandom}; fwd_ready = NFWD'($urandom);
    endtask

    // Puts a valid instruction with op0 = r5 holding val into the stage.
    task automatic load_r5(input logic [DW-1:0] val);
        rand_inputs();
        rst = 0; stall = 0; bubble = 0; in_valid = 1; fwd_reg_write = '0;
        in_op_ids[0 +: IW] = 5'd5; in_op_ids[IW +: IW] = 5'd9; in_ops[0 +: DW] = val;
        tick();
    endtask

    task automatic test_reset();
        rand_inputs();
        stall = 1'($urandom); bubble = 1'($urandom); rst = 1;
        tick();
        rst = 0; stall = 1; bubble = 0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        total++; if (out_pc !== 32'h0 || out_next_pc !== 32'h0 || out_ins !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h/%h/%h exp=0", out_pc, out_next_pc, out_ins); end
        total++; if (out_ops !== '0 || out_immd !== '0 || out_ctrl !== '0 || out_reg_dst_id !== '0) begin bad++; $display("FAIL reset_fields ops=%h immd=%h ctrl=%h dst=%h exp=0", out_ops, out_immd, out_ctrl, out_reg_dst_id); end
        total++; if (out_reg_write !== 1'b0 || out_hazard !== 1'b0) begin bad++; $display("FAIL reset_rw_hz got=%0b/%0b exp=0/0", out_reg_write, out_hazard); end
        total++; if (perf_stall_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", perf_stall_cnt); end
        stall = 0;
    endtask

    task automatic test_priority();
        load_r5(32'h11);
        fwd_reg_write = 2'b11; fwd_dst_id = {5'd5, 5'd5}; fwd_result = {32'hBB, 32'hAA}; fwd_ready = 2'b11;
        #1;
        total++; if (out_ops[0 +: DW] !== 32'hAA) begin bad++; $display("FAIL prio_fwd0 got=%h exp=000000aa", out_ops[0 +: DW]); end
        total++; if (out_ops !== exp_ops_vec() || out_hazard !== 1'b0) begin bad++; $display("FAIL prio_model ops=%h exp=%h hz=%0b", out_ops, exp_ops_vec(), out_hazard); end
        fwd_reg_write = 2'b10;
        #1;
        total++; if (out_ops[0 +: DW] !== 32'hBB) begin bad++; $display("FAIL prio_fwd1 got=%h exp=000000bb", out_ops[0 +: DW]); end
        fwd_reg_write = 2'b00;
        #1;
        total++; if (out_ops[0 +: DW] !== 32'h11) begin bad++; $display("FAIL prio_none got=%h exp=00000011", out_ops[0 +: DW]); end
    endtask

    task automatic test_zero_reg();
        load_r5(32'h0);
        in_op_ids[0 +: IW] = 5'd0;
        tick();
        fwd_reg_write = 2'b01; fwd_dst_id = {5'd3, 5'd0}; fwd_result = {32'h1, 32'hFF}; fwd_ready = 2'b11;
        #1;
        total++; if (out_ops[0 +: DW] !== 32'h0 || out_hazard !== 1'b0) begin bad++; $display("FAIL zero_reg got=%h hz=%0b exp=0 hz=0", out_ops[0 +: DW], out_hazard); end
    endtask

    task automatic test_stall_refresh();
        load_r5(32'h11);
        stall = 1;
        fwd_reg_write = 2'b10; fwd_dst_id = {5'd5, 5'd0}; fwd_result = {32'hCC, 32'h0}; fwd_ready = 2'b10;
        #1;
        total++; if (out_ops[0 +: DW] !== 32'hCC) begin bad++; $display("FAIL refresh_c1 got=%h exp=000000cc", out_ops[0 +: DW]); end
        tick();
        fwd_reg_write = 2'b00;
        #1;
        total++; if (out_ops[0 +: DW] !== 32'hCC || out_hazard !== 1'b0) begin bad++; $display("FAIL refresh_c2 got=%h hz=%0b exp=000000cc", out_ops[0 +: DW], out_hazard); end
        tick();
        total++; if (out_ops[0 +: DW] !== 32'hCC || out_pc !== m_pc || out_valid !== 1'b1) begin bad++; $display("FAIL refresh_hold op=%h pc=%h v=%0b exp=000000cc %h 1", out_ops[0 +: DW], out_pc, out_valid, m_pc); end
        stall = 0;
    endtask

    task automatic test_hazard();
        load_r5(32'h22);
        fwd_reg_write = 2'b11; fwd_dst_id = {5'd5, 5'd5}; fwd_result = {32'hBB, 32'hAA}; fwd_ready = 2'b10;
        #1;
        total++; if (out_hazard !== 1'b1 || out_ops[0 +: DW] !== 32'h22) begin bad++; $display("FAIL hazard_wait hz=%0b op=%h exp=1 00000022", out_hazard, out_ops[0 +: DW]); end
        tick();
        fwd_ready = 2'b11;
        #1;
        total++; if (out_hazard !== 1'b0 || out_ops[0 +: DW] !== 32'hAA) begin bad++; $display("FAIL hazard_clear hz=%0b op=%h exp=0 000000aa", out_hazard, out_ops[0 +: DW]); end
    endtask

    task automatic test_bubble_inert();
        logic [31:0] pc_saved;
        load_r5(32'h33);
        pc_saved = m_pc;
        stall = 1; bubble = 1;
        tick();
        total++; if (out_valid !== 1'b1 || out_pc !== pc_saved) begin bad++; $display("FAIL stall_bubble v=%0b pc=%h exp=1 %h", out_valid, out_pc, pc_saved); end
        stall = 0;
        tick();
        total++; if (out_valid !== 1'b0 || out_reg_write !== 1'b0 || out_pc !== 32'h0 || out_ops !== '0) begin bad++; $display("FAIL bubble v=%0b rw=%0b pc=%h ops=%h exp=0", out_valid, out_reg_write, out_pc, out_ops); end
        bubble = 0; in_valid = 0; in_reg_write = 1; in_op_ids[0 +: IW] = 5'd5; in_ops[0 +: DW] = 32'h44;
        tick();
        fwd_reg_write = 2'b01; fwd_dst_id = {5'd5, 5'd5}; fwd_result = {32'hBB, 32'hAA}; fwd_ready = 2'b00;
        #1;
        total++; if (out_reg_write !== 1'b0 || out_hazard !== 1'b0 || out_ops[0 +: DW] !== 32'h44) begin bad++; $display("FAIL inert rw=%0b hz=%0b op=%h exp=0 0 00000044", out_reg_write, out_hazard, out_ops[0 +: DW]); end
    endtask

    task automatic test_counter();
        rst = 1; tick(); rst = 0;
        stall = 1; tick();
        total++; if (perf_stall_cnt !== 2'd0) begin bad++; $display("FAIL cnt_invalid got=%0d exp=0", perf_stall_cnt); end
        load_r5(32'h55);
        stall = 1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++; if (perf_stall_cnt !== CNTW'(m_cnt)) begin bad++; $display("FAIL cnt_step%0d got=%0d exp=%0d", i, perf_stall_cnt, m_cnt); end
        end
        total++; if (perf_stall_cnt !== 2'd3) begin bad++; $display("FAIL cnt_sat got=%0d exp=3", perf_stall_cnt); end
        stall = 0;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 400; c++) begin
            rand_inputs();
            rst = ($urandom_range(0, 24) == 0); stall = ($urandom_range(0, 2) == 0); bubble = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < NOPS; k++) in_op_ids[k*IW +: IW] = IW'($urandom_range(0, 3));
            for (int j = 0; j < NFWD; j++) fwd_dst_id[j*IW +: IW] = IW'($urandom_range(0, 3));
            #1;
            total++; if (out_valid !== m_valid || out_reg_write !== (m_rw & m_valid)) begin bad++; $display("FAIL rnd%0d_valid v=%0b rw=%0b exp=%0b %0b", c, out_valid, out_reg_write, m_valid, m_rw & m_valid); end
            total++; if (out_pc !== m_pc || out_next_pc !== m_npc || out_ins !== m_ins || out_immd !== m_immd || out_ctrl !== m_ctrl || out_reg_dst_id !== m_dst) begin bad++; $display("FAIL rnd%0d_fields pc=%h/%h npc=%h/%h ins=%h/%h", c, out_pc, m_pc, out_next_pc, m_npc, out_ins, m_ins); end
            total++; if (out_ops !== exp_ops_vec()) begin bad++; $display("FAIL rnd%0d_ops got=%h exp=%h", c, out_ops, exp_ops_vec()); end
            total++; if (out_hazard !== exp_hazard()) begin bad++; $display("FAIL rnd%0d_hazard got=%0b exp=%0b", c, out_hazard, exp_hazard()); end
            total++; if (perf_stall_cnt !== CNTW'(m_cnt)) begin bad++; $display("FAIL rnd%0d_cnt got=%0d exp=%0d", c, perf_stall_cnt, m_cnt); end
            tick();
        end
        rst = 0; stall = 0; bubble = 0;
    endtask

    initial begin
        model_clear(1'b0);
        #2;
        test_reset();
        test_priority();
        test_zero_reg();
        test_stall_refresh();
        test_hazard();
        test_bubble_inert();
        test_counter();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
